// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 key event path.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

    localparam int unsigned PAUSE_SKIP = 7;
    localparam int unsigned SKIP_W     = 3;
    localparam int unsigned KEY_W      = 9;
    localparam int unsigned EVT_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Keyboard status/ack bytes that never start or complete a key event.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
               (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event queue with occupancy count.
module ps2_evt_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = EVT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage, pointers and count; a pop frees the slot a full-queue push reuses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// Scan-code decoder, held-key table and event queue toward the processor.
module ps2_key_event_queue
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [7:0]                    iBYTE,
    input  logic                          iBYTE_VALID,
    input  logic                          iEVT_READY,
    output logic                          oEVT_VALID,
    output logic [7:0]                    oEVT_CODE,
    output logic                          oEVT_EXT,
    output logic                          oEVT_BREAK,
    output logic [$clog2(FIFO_DEPTH):0]   oFIFO_COUNT,
    output logic                          oOVERFLOW,
    output logic [NUM_KEYS-1:0]           oKEY_ON,
    output logic [KEY_W*NUM_KEYS-1:0]     oKEY_CODE
);

    dec_state_t                 state_q, state_d;
    logic [SKIP_W-1:0]          skip_q, skip_d;
    logic                       evt_fire;
    ps2_evt_t                   evt;
    logic [KEY_W-1:0]           evt_key;
    logic [NUM_KEYS-1:0]        key_on_q;
    logic [KEY_W*NUM_KEYS-1:0]  key_code_q;
    logic [NUM_KEYS-1:0]        key_match;
    logic [NUM_KEYS-1:0]        free_oh;
    logic                       is_repeat;
    logic                       evt_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       overflow_q;
    ps2_evt_t                   head;

    // Decoder state and pause-skip counter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Prefix decoding: track E0/F0/E1 and emit a completed event.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        evt_fire = 1'b0;
        evt      = '0;
        evt.code = iBYTE;
        if (iBYTE_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    if (iBYTE == PS2_EXT)        state_d = ST_EXT;
                    else if (iBYTE == PS2_BRK)   state_d = ST_BRK;
                    else if (iBYTE == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_W'(PAUSE_SKIP);
                    end else if (!is_ignored(iBYTE)) evt_fire = 1'b1;
                end
                ST_EXT: begin
                    if (iBYTE == PS2_BRK) state_d = ST_EXT_BRK;
                    else begin
                        state_d  = ST_IDLE;
                        evt.ext  = 1'b1;
                        evt_fire = (iBYTE != PS2_FAKE_SHIFT);
                    end
                end
                ST_BRK: begin
                    state_d  = ST_IDLE;
                    evt.brk  = 1'b1;
                    evt_fire = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_d  = ST_IDLE;
                    evt.ext  = 1'b1;
                    evt.brk  = 1'b1;
                    evt_fire = (iBYTE != PS2_FAKE_SHIFT);
                end
                ST_SKIP: begin
                    if (skip_q <= SKIP_W'(1)) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        skip_d  = skip_q - SKIP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign evt_key = {evt.ext, evt.code};

    // Occupied slots holding the current event's key.
    always_comb begin
        key_match = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            key_match[i] = key_on_q[i] && (key_code_q[KEY_W*i +: KEY_W] == evt_key);
    end

    // One-hot of the lowest-index free slot (all zero when the table is full).
    always_comb begin
        free_oh = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (!key_on_q[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    assign is_repeat = !evt.brk && (|key_match);
    assign evt_push  = evt_fire && !is_repeat;
    assign fifo_pop  = !fifo_empty && iEVT_READY;

    // Held-key table: fill lowest free slot on make, clear all matches on break.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            key_on_q   <= '0;
            key_code_q <= '0;
        end else if (evt_fire) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (evt.brk && key_match[i]) begin
                    key_on_q[i]                   <= 1'b0;
                    key_code_q[KEY_W*i +: KEY_W]  <= '0;
                end else if (!evt.brk && !is_repeat && free_oh[i]) begin
                    key_on_q[i]                   <= 1'b1;
                    key_code_q[KEY_W*i +: KEY_W]  <= evt_key;
                end
            end
        end
    end

    // Sticky flag for events dropped on a full queue with no pop.
    always_ff @(posedge iCLK) begin
        if (iRST)                                   overflow_q <= 1'b0;
        else if (evt_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (iCLK),
        .rst     (iRST),
        .push    (evt_push),
        .wr_data (evt),
        .pop     (fifo_pop),
        .rd_data (head),
        .count   (oFIFO_COUNT),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign oEVT_VALID = !fifo_empty;
    assign oEVT_CODE  = head.code;
    assign oEVT_EXT   = head.ext;
    assign oEVT_BREAK = head.brk;
    assign oOVERFLOW  = overflow_q;
    assign oKEY_ON    = key_on_q;
    assign oKEY_CODE  = key_code_q;

endmodule
